// File: rtl/rd_serial_transmitter.sv
// Memory-backed bit-serial transmitter for the RD detector link: fetches WORD_BITS-wide
// samples from an event buffer and shifts them out LSB first, framed by ENABLE_XFR_OUT.
module rd_serial_transmitter #(
    parameter int WORD_BITS = 13,
    parameter int N_WORDS   = 2048,
    parameter int ADDR_BITS = 11
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic                 DONE_ACK,
    output logic [ADDR_BITS-1:0] MEM_ADDR,
    output logic                 MEM_RD_EN,
    input  logic [31:0]          MEM_DATA,
    output logic                 ENABLE_XFR_OUT,
    output logic                 SERIAL_DATA_OUT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ABORTED,
    output logic [ADDR_BITS:0]   WORDS_SENT
);

    localparam int CNT_BITS = $clog2(WORD_BITS);
    localparam logic [CNT_BITS-1:0]  LAST_BIT   = CNT_BITS'(WORD_BITS - 1);
    localparam logic [CNT_BITS-1:0]  PRE_BIT    = CNT_BITS'(WORD_BITS - 2);
    localparam logic [CNT_BITS-1:0]  CNT_ONE    = CNT_BITS'(1);
    localparam logic [ADDR_BITS:0]   LAST_WORD  = (ADDR_BITS+1)'(N_WORDS - 1);
    localparam logic [ADDR_BITS:0]   WORD_ONE   = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE   = ADDR_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_FLUSH,
        S_FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic                   prev_start_q, prev_start_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic                   rd_en_q, rd_en_d;
    logic                   enable_q, enable_d;
    logic                   serial_q, serial_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;
    logic [ADDR_BITS:0]     words_q, words_d;

    logic                   start_req;
    logic                   cur_bit;
    logic                   mem_data_unused;

    assign mem_data_unused = ^MEM_DATA[31:WORD_BITS];

    // bit_cnt runs one cycle ahead of the registered serial outputs, so bit 0 of each
    // word is taken straight from the buffer read data while it is being captured.
    assign start_req = START && !prev_start_q;
    assign cur_bit   = (bit_cnt_q == '0) ? MEM_DATA[0] : shift_q[bit_cnt_q];

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        prev_start_d = START;
        mem_addr_d   = mem_addr_q;
        rd_en_d      = 1'b0;
        enable_d     = 1'b0;
        serial_d     = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        words_d      = words_q;

        // Completion below overrides an acknowledge landing in the same cycle.
        if (DONE_ACK) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_req && !done_q) begin
                    mem_addr_d = '0;
                    rd_en_d    = 1'b1;
                    busy_d     = 1'b1;
                    words_d    = '0;
                    aborted_d  = 1'b0;
                    bit_cnt_d  = '0;
                    state_d    = S_FETCH;
                end
            end

            S_FETCH: begin
                if (ABORT) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (ABORT) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    enable_d = 1'b1;
                    serial_d = cur_bit;
                    if (bit_cnt_q == '0) begin
                        shift_d = MEM_DATA[WORD_BITS-1:0];
                    end
                    if (bit_cnt_q == PRE_BIT && words_q != LAST_WORD) begin
                        mem_addr_d = mem_addr_q + ADDR_ONE;
                        rd_en_d    = 1'b1;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        words_d   = words_q + WORD_ONE;
                        bit_cnt_d = '0;
                        if (words_q == LAST_WORD) begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
            end

            // Two cycles: the final bit drains out of the output register, then the line idles.
            S_FLUSH: begin
                if (bit_cnt_q == CNT_ONE) begin
                    bit_cnt_d = '0;
                    state_d   = S_FINISH;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            prev_start_q <= 1'b0;
            mem_addr_q   <= '0;
            rd_en_q      <= 1'b0;
            enable_q     <= 1'b0;
            serial_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            prev_start_q <= prev_start_d;
            mem_addr_q   <= mem_addr_d;
            rd_en_q      <= rd_en_d;
            enable_q     <= enable_d;
            serial_q     <= serial_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            words_q      <= words_d;
        end
    end

    assign MEM_ADDR        = mem_addr_q;
    assign MEM_RD_EN       = rd_en_q;
    assign ENABLE_XFR_OUT  = enable_q;
    assign SERIAL_DATA_OUT = serial_q;
    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign ABORTED         = aborted_q;
    assign WORDS_SENT      = words_q;

endmodule

// File: tb/tb_rd_serial_transmitter.sv
// Bench for rd_serial_transmitter: a buffer model with 1-cycle read latency feeds the DUT,
// and a receiver-side deserializer compares the stream against the buffer contents.
module tb_rd_serial_transmitter;

    localparam int WB    = 13;
    localparam int NW    = 2048;
    localparam int NBITS = WB * NW;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        START;
    logic        ABORT;
    logic        DONE_ACK;
    logic [10:0] MEM_ADDR;
    logic        MEM_RD_EN;
    logic [31:0] MEM_DATA;
    logic        ENABLE_XFR_OUT;
    logic        SERIAL_DATA_OUT;
    logic        BUSY;
    logic        DONE;
    logic        ABORTED;
    logic [11:0] WORDS_SENT;

    logic [WB-1:0] mem_words [NW];
    int            junk;
    int            n_tests = 0;
    int            n_fail  = 0;

    rd_serial_transmitter dut (
        .CLK             (CLK),
        .RESETN          (RESETN),
        .START           (START),
        .ABORT           (ABORT),
        .DONE_ACK        (DONE_ACK),
        .MEM_ADDR        (MEM_ADDR),
        .MEM_RD_EN       (MEM_RD_EN),
        .MEM_DATA        (MEM_DATA),
        .ENABLE_XFR_OUT  (ENABLE_XFR_OUT),
        .SERIAL_DATA_OUT (SERIAL_DATA_OUT),
        .BUSY            (BUSY),
        .DONE            (DONE),
        .ABORTED         (ABORTED),
        .WORDS_SENT      (WORDS_SENT)
    );

    always #5 CLK = ~CLK;

    // Event buffer with registered read; the unused upper bits carry random junk.
    always @(posedge CLK) begin
        if (MEM_RD_EN) begin
            junk = $urandom;
            MEM_DATA <= {junk[18:0], mem_words[MEM_ADDR]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, {21'd0, MEM_ADDR}, 0);
        chk({tag, "_rden"}, {31'd0, MEM_RD_EN}, 0);
        chk({tag, "_en"},   {31'd0, ENABLE_XFR_OUT}, 0);
        chk({tag, "_sd"},   {31'd0, SERIAL_DATA_OUT}, 0);
        chk({tag, "_busy"}, {31'd0, BUSY}, 0);
        chk({tag, "_done"}, {31'd0, DONE}, 0);
        chk({tag, "_abt"},  {31'd0, ABORTED}, 0);
        chk({tag, "_ws"},   {20'd0, WORDS_SENT}, 0);
    endtask

    task automatic ack_and_check(input string tag);
        DONE_ACK = 1'b1;
        tick();
        DONE_ACK = 1'b0;
        chk({tag, "_ack_done"}, {31'd0, DONE}, 0);
        chk({tag, "_ack_abt"},  {31'd0, ABORTED}, 0);
    endtask

    // One transfer, observed bit by bit from the receiver's point of view. Output cycle c
    // (0-based from ENABLE rise) carries bit c%13 of word c/13.
    task automatic run_xfer(input string tag, input int abort_at, input int reset_at,
                            input bit ack_finish, input bit hold_start);
        int          en_err = 0;
        int          ws_err = 0;
        int          rd_err = 0;
        logic [WB-1:0] cur = '0;
        bit          exp_rd;
        START = 1'b1;
        tick();
        chk({tag, "_acc_busy"}, {31'd0, BUSY}, 1);
        chk({tag, "_acc_rden"}, {31'd0, MEM_RD_EN}, 1);
        chk({tag, "_acc_addr"}, {21'd0, MEM_ADDR}, 0);
        chk({tag, "_acc_ws"},   {20'd0, WORDS_SENT}, 0);
        if (!hold_start) START = 1'b0;
        tick();
        chk({tag, "_pre_en"}, {31'd0, ENABLE_XFR_OUT}, 0);
        for (int c = 0; c < NBITS; c++) begin
            tick();
            if (hold_start && c == 50) START = 1'b0;
            if (hold_start && c == 51) START = 1'b1;
            if (ENABLE_XFR_OUT !== 1'b1) en_err++;
            if (WORDS_SENT !== 12'((c + 1) / WB)) ws_err++;
            exp_rd = (c % WB == WB - 2) && (c / WB < NW - 1);
            if (MEM_RD_EN !== exp_rd) rd_err++;
            if (c == WB - 2) chk({tag, "_rden_b11"}, {31'd0, MEM_RD_EN}, 1);
            cur[c % WB] = SERIAL_DATA_OUT;
            if (c % WB == WB - 1)
                chk($sformatf("%s_word%0d", tag, c / WB), {19'd0, cur}, {19'd0, mem_words[c / WB]});
            if (c == abort_at) begin
                ABORT = 1'b1;
                tick();
                ABORT = 1'b0;
                START = 1'b0;
                chk({tag, "_ab_en"},   {31'd0, ENABLE_XFR_OUT}, 0);
                chk({tag, "_ab_rden"}, {31'd0, MEM_RD_EN}, 0);
                chk({tag, "_ab_busy"}, {31'd0, BUSY}, 0);
                chk({tag, "_ab_done"}, {31'd0, DONE}, 1);
                chk({tag, "_ab_abt"},  {31'd0, ABORTED}, 1);
                chk({tag, "_ab_ws"},   {20'd0, WORDS_SENT}, (abort_at + 1) / WB);
                chk({tag, "_en_err"}, en_err, 0);
                chk({tag, "_ws_err"}, ws_err, 0);
                chk({tag, "_rd_err"}, rd_err, 0);
                return;
            end
            if (c == reset_at) begin
                START = 1'b0;
                #1 RESETN = 1'b0;
                #1;
                chk_all_zero({tag, "_rst"});
                chk({tag, "_en_err"}, en_err, 0);
                @(posedge CLK);
                @(posedge CLK);
                #1 RESETN = 1'b1;
                tick();
                chk({tag, "_rel_done"}, {31'd0, DONE}, 0);
                chk({tag, "_rel_busy"}, {31'd0, BUSY}, 0);
                return;
            end
        end
        chk({tag, "_en_err"}, en_err, 0);
        chk({tag, "_ws_err"}, ws_err, 0);
        chk({tag, "_rd_err"}, rd_err, 0);
        tick();
        chk({tag, "_end_en"},  {31'd0, ENABLE_XFR_OUT}, 0);
        chk({tag, "_end_done"}, {31'd0, DONE}, 0);
        tick();
        chk({tag, "_fin_done"}, {31'd0, DONE}, 0);
        chk({tag, "_fin_busy"}, {31'd0, BUSY}, 1);
        if (ack_finish) DONE_ACK = 1'b1;
        tick();
        DONE_ACK = 1'b0;
        chk({tag, "_done"},      {31'd0, DONE}, 1);
        chk({tag, "_done_busy"}, {31'd0, BUSY}, 0);
        chk({tag, "_done_abt"},  {31'd0, ABORTED}, 0);
        chk({tag, "_ws_full"},   {20'd0, WORDS_SENT}, NW);
        chk({tag, "_addr_last"}, {21'd0, MEM_ADDR}, NW - 1);
    endtask

    initial begin
        RESETN   = 1'b0;
        START    = 1'b0;
        ABORT    = 1'b0;
        DONE_ACK = 1'b0;
        for (int i = 0; i < NW; i++) mem_words[i] = WB'(i & 16'h1FFF);
        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RESETN = 1'b1;
        tick();

        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("idle_abort_done", {31'd0, DONE}, 0);
        chk("idle_abort_busy", {31'd0, BUSY}, 0);

        // Ramp buffer, START held with an extra edge mid-transfer, DONE_ACK on completion.
        run_xfer("ramp", -1, -1, 1'b1, 1'b1);
        tick();
        chk("ack_in_finish_done", {31'd0, DONE}, 1);
        START = 1'b0;
        tick();
        START = 1'b1;
        tick();
        tick();
        chk("start_while_done_busy", {31'd0, BUSY}, 0);
        chk("start_while_done_en", {31'd0, ENABLE_XFR_OUT}, 0);
        START = 1'b0;
        ack_and_check("ramp");

        // Alternating patterns across the first word boundary.
        for (int i = 0; i < NW; i++) mem_words[i] = WB'($urandom);
        mem_words[0] = 13'h1555;
        mem_words[1] = 13'h0AAA;
        run_xfer("bound", 2 * WB, -1, 1'b0, 1'b0);
        ack_and_check("bound");

        for (int i = 0; i < NW; i++) mem_words[i] = WB'($urandom);
        run_xfer("abort100", 100, -1, 1'b0, 1'b0);
        ack_and_check("abort100");

        for (int i = 0; i < NW; i++) mem_words[i] = WB'($urandom);
        run_xfer("rst1000", -1, 1000 * WB + 4, 1'b0, 1'b0);
        run_xfer("post_rst", -1, -1, 1'b0, 1'b0);
        tick();
        chk("post_rst_done_hold", {31'd0, DONE}, 1);
        ack_and_check("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
